// File: rtl/board_io_pkg.sv
// Shared constants and helpers for the board I/O conditioning block.
package board_io_pkg;

    localparam int PWM_BITS_DEFAULT     = 8;
    localparam int DEBOUNCE_100MHZ_10MS = 1000000;

    // Debounce counter only has to reach cycles-1, so $clog2(cycles) bits suffice.
    function automatic int debounce_cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Single-bit two-flop synchroniser, debounce counter and rise/fall pulse generator.
module io_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ_10MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CW       = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where s2 agrees with the accepted level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
                rise_d   = s2_q;
                fall_d   = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= din_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O conditioning: debounced buttons/switches with edge pulses, PWM-driven LEDs.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int NUM_SW          = 4,
    parameter int NUM_LED         = 4,
    parameter int NUM_RGB         = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ_10MS,
    parameter int PWM_BITS        = PWM_BITS_DEFAULT
) (
    input  logic                            CLK100MHZ,
    input  logic                            reset_n,
    input  logic [NUM_BTN-1:0]              btn_in,
    input  logic [NUM_SW-1:0]               sw_in,
    output logic [NUM_BTN-1:0]              btn_level,
    output logic [NUM_BTN-1:0]              btn_rise,
    output logic [NUM_BTN-1:0]              btn_fall,
    output logic [NUM_SW-1:0]               sw_level,
    output logic [NUM_SW-1:0]               sw_changed,
    input  logic                            pwm_enable,
    input  logic [NUM_LED*PWM_BITS-1:0]     led_duty,
    input  logic [3*NUM_RGB*PWM_BITS-1:0]   rgb_duty,
    output logic [NUM_LED-1:0]              led_out,
    output logic [3*NUM_RGB-1:0]            rgb_led_out,
    output logic                            pwm_period_start
);

    localparam int NUM_CH = NUM_LED + 3 * NUM_RGB;

    logic [NUM_SW-1:0] sw_rise;
    logic [NUM_SW-1:0] sw_fall;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk     (CLK100MHZ),
                .rst_n   (reset_n),
                .din_i   (btn_in[gi]),
                .level_o (btn_level[gi]),
                .rise_o  (btn_rise[gi]),
                .fall_o  (btn_fall[gi])
            );
        end
        for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
            io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk     (CLK100MHZ),
                .rst_n   (reset_n),
                .din_i   (sw_in[gi]),
                .level_o (sw_level[gi]),
                .rise_o  (sw_rise[gi]),
                .fall_o  (sw_fall[gi])
            );
        end
    endgenerate

    assign sw_changed = sw_rise | sw_fall;

    logic [PWM_BITS-1:0]        cnt_q, cnt_d;
    logic                       wrap;
    logic [NUM_CH*PWM_BITS-1:0] duty_in;
    logic [NUM_CH-1:0]          pwm_q, pwm_d;

    assign cnt_d   = cnt_q + 1'b1;
    assign wrap    = &cnt_q;
    assign duty_in = {rgb_duty, led_duty};

    // Duties are sampled only as the counter wraps, so a period never mixes two duties.
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_pwm
            logic [PWM_BITS-1:0] duty_q, duty_d;

            assign duty_d    = wrap ? duty_in[gi*PWM_BITS +: PWM_BITS] : duty_q;
            assign pwm_d[gi] = pwm_enable & (cnt_q < duty_q);

            always_ff @(posedge CLK100MHZ or negedge reset_n) begin
                if (!reset_n) begin
                    duty_q <= '0;
                end else begin
                    duty_q <= duty_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            pwm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign led_out     = pwm_q[NUM_LED-1:0];
    assign rgb_led_out = pwm_q[NUM_CH-1:NUM_LED];

    // Counter sits at 0 while in reset; gating keeps the pulse low until release.
    assign pwm_period_start = reset_n & (cnt_q == '0);

endmodule
